dmem_lsu: RTL and testbench

- Load/store unit: the initiator side of the data-memory port.
- Takes byte, halfword and word load/store requests from the core datapath. Drives the word-wide dmem interface (A, WD, WE; combinational RD).
- Sub-word stores are done by read-modify-write. Sub-word loads are extracted and extended.
- Misaligned and out-of-range accesses are flagged and never reach memory.

---
 rtl/dmem_lsu_pkg.sv | 35 +++
 rtl/dmem_lsu_align.sv | 51 +++++
 rtl/dmem_lsu.sv | 148 ++++++++++++++
 tb/tb_dmem_lsu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   - request size encodings
//   - FSM state encoding
//   - byte-lane masks and the lane shift helper used by the align logic
package dmem_lsu_pkg;

  // Request size encodings (req_size)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Lane masks before shifting to the addressed lane
  localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_LANE_MASK = 32'h0000_FFFF;

  // Bit offset of the addressed lane inside the word (little-endian).
  // Bytes use addr[1:0], halves use addr[1], words always start at bit 0.
  function automatic logic [4:0] lane_shift(input logic [1:0] addr_lo,
                                            input logic [1:0] size);
    logic [4:0] sh;
    sh = 5'd0;
    if (size == SZ_BYTE)      sh = {addr_lo, 3'b000};
    else if (size == SZ_HALF) sh = {addr_lo[1], 4'b0000};
    return sh;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   i_word      : word read from memory
//   i_addr_lo   : byte address bits [1:0]
//   i_size      : request size (byte/half/word)
//   i_signed    : sign-extend a sub-word extraction
//   i_wdata     : store data (low byte/half used for sub-word sizes)
//   o_merged    : i_word with the addressed lane replaced by store data
//   o_extracted : addressed lane shifted to bit 0 and zero/sign extended
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_extracted
);

  logic [4:0]  w_sh;
  logic [31:0] w_mask;
  logic [31:0] w_lane;

  assign w_sh   = lane_shift(i_addr_lo, i_size);
  assign w_lane = i_word >> w_sh;

  always_comb begin
    w_mask      = '1;
    o_merged    = i_wdata;
    o_extracted = i_word;
    case (i_size)
      SZ_BYTE: begin
        w_mask      = BYTE_LANE_MASK << w_sh;
        o_merged    = (i_word & ~w_mask) | ((i_wdata & BYTE_LANE_MASK) << w_sh);
        o_extracted = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
      end
      SZ_HALF: begin
        w_mask      = HALF_LANE_MASK << w_sh;
        o_merged    = (i_word & ~w_mask) | ((i_wdata & HALF_LANE_MASK) << w_sh);
        o_extracted = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
      end
      default: begin
        // Word (and the never-issued illegal size): whole word, no extension.
        o_merged    = i_wdata;
        o_extracted = i_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving a word-wide data memory port.
// Sub-word stores use read-modify-write; sub-word loads are extracted and
// extended. Misaligned, out-of-range and illegal-size requests complete with
// resp_err and never touch memory.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; all req_* fields are captured then. req_ready is
// high only in IDLE. resp_valid is a one-cycle pulse with no backpressure.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   req_valid/ready/we/size/signed   request handshake and attributes
//   req_addr, req_wdata              byte address, store data
//   resp_valid, resp_rdata, resp_err completion pulse, load data, error flag
//   mem_a, mem_wd, mem_we            word-aligned dmem address/data/write
//   mem_rd                           combinational dmem read data
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  state_e      r_state;
  state_e      w_state_nxt;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_load_data;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;

  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_merged;
  logic [31:0] w_extracted;

  assign w_req_err = (req_size == SZ_ILL)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                   | (req_addr >= MEM_BYTES);

  // Align logic works on the captured request and live read data, so during
  // READ it yields both the merged store word and the extracted load value.
  lsu_align u_align (
    .i_word      (mem_rd),
    .i_addr_lo   (r_addr_lo),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_wdata     (r_wdata),
    .o_merged    (w_merged),
    .o_extracted (w_extracted)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_we      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        w_accept  = req_valid;
        if (req_valid) begin
          if (w_req_err)                          w_state_nxt = ST_RESP;
          else if (req_we && req_size == SZ_WORD) w_state_nxt = ST_WRITE;
          else                                    w_state_nxt = ST_READ;
        end
      end
      ST_READ:  w_state_nxt = r_we ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        mem_we      = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_load_data <= '0;
      r_mem_a     <= '0;
      r_mem_wd    <= '0;
    end else begin
      if (w_accept) begin
        r_we      <= req_we;
        r_size    <= req_size;
        r_signed  <= req_signed;
        r_addr_lo <= req_addr[1:0];
        r_wdata   <= req_wdata;
        r_err     <= w_req_err;
        // Errored requests leave the memory port untouched.
        if (!w_req_err) begin
          r_mem_a <= {req_addr[31:2], 2'b00};
          if (req_we && req_size == SZ_WORD) r_mem_wd <= req_wdata;
        end
      end
      if (r_state == ST_READ) begin
        if (r_we) r_mem_wd    <= w_merged;
        else      r_load_data <= w_extracted;
      end
    end
  end

  assign mem_a      = r_mem_a;
  assign mem_wd     = r_mem_wd;
  assign resp_err   = resp_valid & r_err;
  assign resp_rdata = (resp_valid && !r_we && !r_err) ? r_load_data : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;
  int g_we   = 0;
  int g_resp = 0;

  logic [31:0] mem [64];

  dmem_lsu #(.MEM_WORDS(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
  );

  // ---------------- clock / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
      g_we <= g_we + 1;
    end
    if (resp_valid) g_resp <= g_resp + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_timeout got=%b want=1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for resp_valid; latency counts cycles after acceptance.
  task automatic wait_resp(output int lat, output logic [31:0] rdata, output logic err,
                           output int we_cyc, output logic [31:0] we_a,
                           output logic [31:0] we_wd, output int we_n);
    lat = -1; rdata = '0; err = 1'b0; we_cyc = -1; we_a = '0; we_wd = '0; we_n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) begin
        we_n++;
        if (we_cyc < 0) begin
          we_cyc = c; we_a = mem_a; we_wd = mem_wd;
        end
      end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got=%b want=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got=%h want=0", resp_rdata); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL rst_mem_a got=%h want=0", mem_a); end
    checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL rst_mem_wd got=%h want=0", mem_wd); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_word_store_load();
    int lat, wc, wn; logic [31:0] rd, wa, wwd; logic er;
    issue(1'b1, SZ_WORD, 1'b0, 32'h0, 32'hFFFF_0000);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wst_latency got=%0d want=2", lat); end
    checks++; if (wc !== 1 || wn !== 1) begin errors++; $display("FAIL wst_we_cycle got=%0d/%0d want=1/1", wc, wn); end
    checks++; if (wa !== 32'h0) begin errors++; $display("FAIL wst_mem_a got=%h want=0", wa); end
    checks++; if (wwd !== 32'hFFFF_0000) begin errors++; $display("FAIL wst_mem_wd got=%h want=ffff0000", wwd); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wst_resp got=%b/%h want=0/0", er, rd); end
    issue(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wld_latency got=%0d want=2", lat); end
    checks++; if (rd !== 32'hFFFF_0000) begin errors++; $display("FAIL wld_rdata got=%h want=ffff0000", rd); end
    checks++; if (er !== 1'b0 || wn !== 0) begin errors++; $display("FAIL wld_err_we got=%b/%0d want=0/0", er, wn); end
  endtask

  task automatic test_byte_store();
    int lat, wc, wn; logic [31:0] rd, wa, wwd; logic er;
    issue(1'b1, SZ_WORD, 1'b0, 32'h4, 32'h1122_3344);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h5, 32'h0000_00AB);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bst_latency got=%0d want=3", lat); end
    checks++; if (wc !== 2 || wn !== 1) begin errors++; $display("FAIL bst_we_cycle got=%0d/%0d want=2/1", wc, wn); end
    checks++; if (wa !== 32'h4) begin errors++; $display("FAIL bst_mem_a got=%h want=4", wa); end
    checks++; if (wwd !== 32'h1122_AB44) begin errors++; $display("FAIL bst_mem_wd got=%h want=1122ab44", wwd); end
    issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (rd !== 32'h1122_AB44) begin errors++; $display("FAIL bst_readback got=%h want=1122ab44", rd); end
    // Half store to upper lane of word 0x4
    issue(1'b1, SZ_HALF, 1'b0, 32'h6, 32'h1234_BEEF);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (wwd !== 32'hBEEF_AB44 || lat !== 3) begin errors++; $display("FAIL hst_merge got=%h/%0d want=beefab44/3", wwd, lat); end
  endtask

  task automatic test_subword_loads();
    logic [31:0] addr_t [6];
    logic [1:0]  size_t [6];
    logic        sgn_t  [6];
    logic [31:0] exp_t  [6];
    int lat, wc, wn; logic [31:0] rd, wa, wwd; logic er;
    addr_t = '{32'h3, 32'h3, 32'h0, 32'h2, 32'h2, 32'h5};
    size_t = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_HALF, SZ_BYTE};
    sgn_t  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t  = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFAB};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, size_t[i], sgn_t[i], addr_t[i], 32'h0);
      wait_resp(lat, rd, er, wc, wa, wwd, wn);
      checks++;
      if (rd !== exp_t[i] || lat !== 2 || er !== 1'b0) begin
        errors++;
        $display("FAIL subload_%0d got=%h lat=%0d err=%b want=%h lat=2 err=0", i, rd, lat, er, exp_t[i]);
      end
    end
  endtask

  task automatic test_errors();
    int lat, wc, wn; logic [31:0] rd, wa, wwd; logic er;
    issue(1'b1, SZ_HALF, 1'b0, 32'h1, 32'h0000_5555);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL err_half_st got=%0d/%b want=1/1", lat, er); end
    checks++; if (wn !== 0) begin errors++; $display("FAIL err_half_we got=%0d want=0", wn); end
    checks++; if (mem[0] !== 32'hFFFF_0000) begin errors++; $display("FAIL err_word0 got=%h want=ffff0000", mem[0]); end
    issue(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_range got=%0d/%b/%h want=1/1/0", lat, er, rd); end
    issue(1'b0, SZ_ILL, 1'b0, 32'h0, 32'h0);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_size got=%b/%h want=1/0", er, rd); end
    issue(1'b1, SZ_WORD, 1'b0, 32'h2, 32'hDEAD_BEEF);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (er !== 1'b1 || wn !== 0) begin errors++; $display("FAIL err_word_mis got=%b/%0d want=1/0", er, wn); end
    // Last in-range byte is legal
    issue(1'b0, SZ_BYTE, 1'b0, 32'hFF, 32'h0);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (er !== 1'b0 || lat !== 2 || rd !== 32'h0) begin errors++; $display("FAIL edge_ff got=%b/%0d/%h want=0/2/0", er, lat, rd); end
  endtask

  task automatic test_capture();
    int lat, wc, wn; logic [31:0] rd, wa, wwd; logic er;
    issue(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    req_addr = 32'h101; req_size = SZ_ILL; req_we = 1'b1;
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (rd !== 32'hFFFF_0000 || er !== 1'b0 || wn !== 0) begin errors++; $display("FAIL capture got=%h/%b/%0d want=ffff0000/0/0", rd, er, wn); end
  endtask

  task automatic test_back_to_back();
    int lat, wc, wn; logic [31:0] rd, wa, wwd; logic er;
    issue(1'b0, SZ_HALF, 1'b0, 32'h2, 32'h0);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    // At the RESP cycle: present the next request immediately
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_resp got=%b want=0", req_ready); end
    req_we = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0; req_addr = 32'h2; req_valid = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got=%b want=1", req_ready); end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after got=%b want=0", req_ready); end
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (rd !== 32'h0000_00FF || lat !== 2) begin errors++; $display("FAIL b2b_load got=%h/%0d want=000000ff/2", rd, lat); end
  endtask

  task automatic test_reset_mid();
    int we0, resp0, lat, wc, wn; logic [31:0] rd, wa, wwd; logic er;
    logic [31:0] word1;
    word1 = mem[1];
    issue(1'b1, SZ_BYTE, 1'b0, 32'h6, 32'h0000_0055);
    we0 = g_we; resp0 = g_resp;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || req_ready !== 1'b0 || mem_a !== 32'h4) begin errors++; $display("FAIL rmid_read got=%b/%b/%h want=0/0/4", mem_we, req_ready, mem_a); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_a !== 32'h0 || mem_wd !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_mem got=%h/%h/%b want=0/0/0", mem_a, mem_wd, mem_we); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL rmid_resp got=%b/%b/%h want=0/0/0", resp_valid, resp_err, resp_rdata); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (g_we !== we0 || g_resp !== resp0) begin errors++; $display("FAIL rmid_quiet got=%0d/%0d want=0/0", g_we - we0, g_resp - resp0); end
    checks++; if (mem[1] !== word1) begin errors++; $display("FAIL rmid_word4 got=%h want=%h", mem[1], word1); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b want=1", req_ready); end
    issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    wait_resp(lat, rd, er, wc, wa, wwd, wn);
    checks++; if (rd !== 32'hBEEF_AB44 || lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL rmid_after got=%h/%0d/%b want=beefab44/2/0", rd, lat, er); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_subword_loads();
    test_errors();
    test_capture();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
